serial_addsub_ctrl: RTL and testbench
=====================================

// Module: serial_addsub_ctrl
// PURPOSE
//   Bit-serial WIDTH-bit add/subtract sequencer. Accepts one operand pair per
//   transaction and sequences a single shared one-bit add/sub cell (two half
//   adders / half subtractors plus a carry/borrow flop) LSB-first, one bit per clock.
//   Sits between a request source and a result consumer; valid/ready on both sides.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 1..32
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   req_valid  in   1      operand pair valid
//   req_ready  out  1      controller can accept (high only in IDLE)
//   req_op     in   1      0 = add (a+b), 1 = subtract (a-b)
//   req_a      in   WIDTH  operand a (minuend for subtract)
//   req_b      in   WIDTH  operand b (subtrahend for subtract)
//   res_valid  out  1      result valid (high only in DONE)
//   res_ready  in   1      consumer accepts result
//   res_data   out  WIDTH  sum or difference, modulo 2^WIDTH
//   res_cout   out  1      final carry (add) or final borrow (subtract)
//   busy       out  1      high in RUN or DONE
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, req_ready=1 after release, res_valid=0,
//     res_data=0, res_cout=0, busy=0, internal carry/borrow flop=0, bit counter=0.
//   - FSM: IDLE -> RUN on req_valid&req_ready; RUN -> DONE when counter==WIDTH-1
//     at the edge; DONE -> IDLE on res_valid&res_ready. No other transitions.
//   - Accept (IDLE, req_valid=1): latch a, b, op; clear carry/borrow flop; counter=0.
//   - RUN, bit i = counter: ai=a_sh[0], bi=b_sh[0], c=carry/borrow flop.
//     add: s=ai^bi^c; c'=(ai&bi)|(c&(ai^bi)).
//     sub: d=ai^bi^c; c'=(~ai&bi)|(c&~(ai^bi)).
//     Result bit shifted into MSB of result register (shift right); a_sh, b_sh
//     shift right; counter++. After WIDTH RUN cycles result register holds
//     bit0..bitWIDTH-1 in place.
//   - Latency: result visible WIDTH+1 edges after the accept edge (1 accept + WIDTH
//     RUN cycles; res_valid rises on the edge completing bit WIDTH-1).
//   - res_data/res_cout change only on the RUN->DONE edge and hold stable while
//     res_valid=1 regardless of req_* activity; they keep last value in IDLE.
//   - Back-pressure: DONE held indefinitely while res_ready=0.
//   - Throughput: min WIDTH+2 cycles per transaction (DONE->IDLE costs one cycle;
//     no accept in DONE even if res_ready=1).
//   - req_valid while busy: ignored, req_ready=0; requester must hold.
//   - req_op/req_a/req_b changes during RUN: no effect (latched copies used).
//   - WIDTH=1: RUN lasts exactly one cycle; counter width is 1.
//   - Reset mid-RUN or in DONE: transaction discarded, no res_valid produced.
//   - res_cout: add = unsigned overflow; sub = 1 iff a<b (unsigned).
// STRUCTURE
//   - Shared package addsub_pkg: typedef enum {ST_IDLE, ST_RUN, ST_DONE} state_t;
//     localparam OP_ADD=1'b0, OP_SUB=1'b1; function cnt_w(WIDTH) =
//     (WIDTH>1)?$clog2(WIDTH):1.
//   - One sub-module: addsub_bit_cell (in ai, bi, ci, op; out r, co), purely
//     combinational, built from two half-add/sub stages plus OR; instanced once.
//   - Top holds FSM, counter, operand shift registers, carry flop, result reg.
// TESTING
//   1. add 8'hFF + 8'h01, res_ready=1 -> res_valid 9 edges after accept,
//      res_data=8'h00, res_cout=1.
//   2. sub 8'h05 - 8'h07 -> res_data=8'hFE, res_cout=1; sub 8'h07-8'h05 ->
//      8'h02, cout 0.
//   3. res_ready=0 for 20 cycles after DONE -> res_valid/res_data stable, req_ready=0,
//      busy=1; raise res_ready -> IDLE next edge, req_ready=1.
//   4. req_valid with new operands during RUN (cycle 3) -> ignored; first result
//      unaffected (add 8'h3C+8'h0F -> 8'h4B, cout 0).
//   5. assert rst at RUN cycle 4 -> all outputs zero immediately, no res_valid;
//      after release new add 8'h80+8'h80 -> 8'h00, cout 1.
//   6. WIDTH=1 build: add 1+1 -> data 0, cout 1, res_valid 2 edges after accept.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the bit-serial add/subtract sequencer.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit add/subtract cell: two half-add/sub stages joined by an OR on the
// carry/borrow terms. Purely combinational.
//   ai, bi : operand bits (ai is the minuend bit when subtracting)
//   ci     : incoming carry (add) or borrow (subtract)
//   op     : OP_ADD / OP_SUB
//   r      : sum / difference bit
//   co     : outgoing carry / borrow
module addsub_bit_cell
  import addsub_pkg::*;
(
  input  logic ai,
  input  logic bi,
  input  logic ci,
  input  logic op,
  output logic r,
  output logic co
);

  logic is_sub;
  logic h1;
  logic g1;
  logic g2;

  assign is_sub = (op == OP_SUB);

  // First stage: ai (+/-) bi. Inverting the minuend turns generate into borrow.
  assign h1 = ai ^ bi;
  assign g1 = (ai ^ is_sub) & bi;

  // Second stage: h1 (+/-) ci.
  assign r  = h1 ^ ci;
  assign g2 = (h1 ^ is_sub) & ci;

  assign co = g1 | g2;

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer with valid/ready on both sides.
// One operand pair is latched per transaction and processed LSB-first, one bit
// per clock, through a single shared addsub_bit_cell.
//   clk, rst             : clock, asynchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_op, req_a, req_b : 0 = a+b, 1 = a-b
//   res_valid/res_ready  : result handshake (valid only in DONE)
//   res_data, res_cout   : result modulo 2^WIDTH, final carry/borrow
//   busy                 : high in RUN or DONE
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             busy
);

  localparam int unsigned CW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             carry_q, carry_d;
  logic             res_cout_q, res_cout_d;
  logic             req_ready_q, req_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;

  logic accept;
  logic last_bit;
  logic cell_r;
  logic cell_co;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign last_bit = (state_q == ST_RUN) && (cnt_q == CW'(WIDTH - 1));

  addsub_bit_cell u_cell (
    .ai (a_sh_q[0]),
    .bi (b_sh_q[0]),
    .ci (carry_q),
    .op (op_q),
    .r  (cell_r),
    .co (cell_co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)    state_d = ST_RUN;
      ST_RUN:  if (last_bit)  state_d = ST_DONE;
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the upcoming state.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Datapath: latch on accept, shift one bit per RUN cycle, publish on the last bit.
  always_comb begin
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    acc_d      = acc_q;
    op_d       = op_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_cout_d = res_cout_q;
    if (accept) begin
      a_sh_d  = req_a;
      b_sh_d  = req_b;
      op_d    = req_op;
      carry_d = 1'b0;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      // New bit enters at the MSB so bit 0 lands in place after WIDTH shifts.
      acc_d   = (acc_q >> 1) | (WIDTH'(cell_r) << (WIDTH - 1));
      carry_d = cell_co;
      cnt_d   = cnt_q + CW'(1);
      if (last_bit) begin
        cnt_d      = '0;
        res_data_d = acc_d;
        res_cout_d = cell_co;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      op_q        <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_cout_q  <= 1'b0;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_cout_q  <= res_cout_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign res_data  = res_data_q;
  assign res_cout  = res_cout_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl: an 8-bit instance and a 1-bit instance.
module tb_serial_addsub_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_op;
  logic [W-1:0] req_a, req_b;
  logic         res_valid, res_ready, res_cout, busy;
  logic [W-1:0] res_data;

  logic         w1_req_valid, w1_req_ready, w1_req_op;
  logic [0:0]   w1_req_a, w1_req_b, w1_res_data;
  logic         w1_res_valid, w1_res_ready, w1_res_cout, w1_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cout(res_cout), .busy(busy)
  );

  serial_addsub_ctrl #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst),
    .req_valid(w1_req_valid), .req_ready(w1_req_ready), .req_op(w1_req_op),
    .req_a(w1_req_a), .req_b(w1_req_b),
    .res_valid(w1_res_valid), .res_ready(w1_res_ready),
    .res_data(w1_res_data), .res_cout(w1_res_cout), .busy(w1_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction on the 8-bit instance with res_ready held high.
  task automatic run_txn(input string tag, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_d, input logic exp_c);
    int lat;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), W + 1);
    check_eq({tag, "_data"}, 32'(res_data), 32'(exp_d));
    check_eq({tag, "_cout"}, 32'(res_cout), 32'(exp_c));
    @(posedge clk); #1;
  endtask

  // Full transaction on the 1-bit instance.
  task automatic run_txn_w1(input string tag, input logic op, input logic a, input logic b,
                            input logic exp_d, input logic exp_c);
    int lat;
    @(negedge clk);
    w1_req_op = op; w1_req_a = a; w1_req_b = b; w1_req_valid = 1'b1;
    @(posedge clk); #1;
    w1_req_valid = 1'b0;
    lat = 1;
    while (!w1_res_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 2);
    check_eq({tag, "_data"}, 32'(w1_res_data), 32'(exp_d));
    check_eq({tag, "_cout"}, 32'(w1_res_cout), 32'(exp_c));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  wait_cnt;
    logic stable;
    logic no_valid;

    rst = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; res_ready = 1'b1;
    w1_req_valid = 1'b0; w1_req_op = 1'b0; w1_req_a = '0; w1_req_b = '0; w1_res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 1);
    check_eq("rst_res_valid", 32'(res_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_res_data", 32'(res_data), 0);
    check_eq("rst_res_cout", 32'(res_cout), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic vectors.
    run_txn("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1);
    run_txn("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b1);
    run_txn("sub_07_05", 1'b1, 8'h07, 8'h05, 8'h02, 1'b0);
    run_txn("add_12_34", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0);
    run_txn("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0);
    run_txn("sub_00_00", 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);

    // Back-pressure: hold DONE for 20 cycles with req_* toggling.
    @(negedge clk);
    res_ready = 1'b0;
    req_op = 1'b0; req_a = 8'hA5; req_b = 8'h5A; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_cnt = 0;
    while (!res_valid && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check_eq("bp_data", 32'(res_data), 32'h00FF);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = i[0]; req_a = 8'(i); req_b = 8'(3 * i); req_op = i[1];
      if (!res_valid || res_data !== 8'hFF || res_cout !== 1'b0 || req_ready || !busy)
        stable = 1'b0;
    end
    check_eq("bp_hold_stable", 32'(stable), 1);
    @(negedge clk);
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_ready", 32'(req_ready), 1);
    check_eq("bp_release_valid", 32'(res_valid), 0);
    check_eq("bp_release_busy", 32'(busy), 0);
    check_eq("bp_idle_data_held", 32'(res_data), 32'h00FF);

    // Request while busy is ignored.
    @(negedge clk);
    req_op = 1'b0; req_a = 8'h3C; req_b = 8'h0F; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_op = 1'b1; req_a = 8'hFF; req_b = 8'h11; req_valid = 1'b1;
    #1;
    check_eq("busy_req_ready", 32'(req_ready), 0);
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    wait_cnt = 0;
    while (!res_valid && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check_eq("busy_data", 32'(res_data), 32'h004B);
    check_eq("busy_cout", 32'(res_cout), 0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("busy_no_extra_txn", 32'(busy), 0);

    // Reset in the middle of RUN.
    @(negedge clk);
    req_op = 1'b0; req_a = 8'h55; req_b = 8'h22; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_res_valid", 32'(res_valid), 0);
    check_eq("mid_rst_res_data", 32'(res_data), 0);
    check_eq("mid_rst_res_cout", 32'(res_cout), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    check_eq("mid_rst_req_ready", 32'(req_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    no_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid || busy) no_valid = 1'b0;
    end
    check_eq("mid_rst_discarded", 32'(no_valid), 1);
    run_txn("add_80_80", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1);

    // 1-bit instance.
    run_txn_w1("w1_add_1_1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    run_txn_w1("w1_sub_0_1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    run_txn_w1("w1_add_1_0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
